// File: rtl/fetch_ctl.sv
// Instruction fetch controller: sequences the fetch PC, tracks the decode-stage
// address, redirects on taken branches with a fixed squash window and emits link writes.
module fetch_ctl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          FLUSH_CYC = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_rdy,
    input  logic        hold,
    input  logic        ib,
    input  logic [31:0] bv,
    input  logic        bl,
    output logic [31:0] pc,
    output logic        ifetch,
    output logic [31:0] pc_dec,
    output logic        ispb,
    output logic        lr_we,
    output logic [31:0] lr_val
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};
    localparam logic [1:0]  FLUSH_INIT = 2'(FLUSH_CYC);

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_dec_q, pc_dec_d;
    logic [31:0] lr_val_q, lr_val_d;
    logic        ispb_q, ispb_d;
    logic        ifetch_q, ifetch_d;
    logic        lr_we_q, lr_we_d;

    logic        take_branch;
    logic        advance;
    logic [31:0] bv_w;

    assign bv_w        = {bv[31:2], 2'b00};
    assign take_branch = (state_q == RUN) && !hold && ib;
    // Sequential step happens whenever memory delivers and nothing stalls,
    // except in RUN where a taken branch has priority over the next fetch.
    assign advance     = imem_rdy && !hold &&
                         (((state_q == RUN) && !ib) || (state_q == WAIT) || (state_q == FLUSH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            pc_q     <= RESET_PC_W;
            pc_dec_q <= RESET_PC_W;
            ispb_q   <= 1'b0;
            ifetch_q <= 1'b0;
            lr_we_q  <= 1'b0;
            lr_val_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pc_q     <= pc_d;
            pc_dec_q <= pc_dec_d;
            ispb_q   <= ispb_d;
            ifetch_q <= ifetch_d;
            lr_we_q  <= lr_we_d;
            lr_val_q <= lr_val_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (!hold) begin
                    if (ib) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end else if (!imem_rdy) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_rdy && !hold) begin
                    state_d = RUN;
                end
            end
            FLUSH: begin
                // The squash window ends on the cycle the counter reaches one.
                cnt_d = cnt_q - 2'd1;
                if (cnt_q <= 2'd1) begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_comb begin
        pc_d     = pc_q;
        pc_dec_d = pc_dec_q;
        lr_we_d  = 1'b0;
        lr_val_d = lr_val_q;
        ifetch_d = 1'b1;
        ispb_d   = (state_d == FLUSH);
        if (take_branch) begin
            pc_d = pc_dec_q + 32'd8 + bv_w;
            if (bl) begin
                lr_we_d  = 1'b1;
                lr_val_d = pc_dec_q + 32'd4;
            end
        end else if (advance) begin
            pc_dec_d = pc_q;
            pc_d     = pc_q + 32'd4;
        end
    end

    assign pc     = pc_q;
    assign pc_dec = pc_dec_q;
    assign ispb   = ispb_q;
    assign ifetch = ifetch_q;
    assign lr_we  = lr_we_q;
    assign lr_val = lr_val_q;

endmodule

// File: tb/tb_fetch_ctl.sv
// Self-checking bench for fetch_ctl: two instances (1 and 3 squash cycles) share
// stimulus; a scoreboard compares every cycle against a behavioural model.
module tb_fetch_ctl;

    localparam logic [31:0] RESET_A = 32'h0000_0000;
    localparam logic [31:0] RESET_B = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_rdy = 1'b0;
    logic        hold = 1'b0;
    logic        ib = 1'b0;
    logic [31:0] bv = 32'h0;
    logic        bl = 1'b0;

    logic [31:0] pcA, pcDecA, lrValA, pcB, pcDecB, lrValB;
    logic        ifetchA, ispbA, lrWeA, ifetchB, ispbB, lrWeB;

    fetch_ctl #(.RESET_PC(RESET_A), .FLUSH_CYC(1)) dutA (
        .clk(clk), .rst(rst), .imem_rdy(imem_rdy), .hold(hold), .ib(ib), .bv(bv), .bl(bl),
        .pc(pcA), .ifetch(ifetchA), .pc_dec(pcDecA), .ispb(ispbA), .lr_we(lrWeA), .lr_val(lrValA)
    );

    fetch_ctl #(.RESET_PC(RESET_B), .FLUSH_CYC(3)) dutB (
        .clk(clk), .rst(rst), .imem_rdy(imem_rdy), .hold(hold), .ib(ib), .bv(bv), .bl(bl),
        .pc(pcB), .ifetch(ifetchB), .pc_dec(pcDecB), .ispb(ispbB), .lr_we(lrWeB), .lr_val(lrValB)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pcDec;
        logic [31:0] lrVal;
        logic        lrWe;
        logic        ispb;
        logic        ifetch;
        logic        waiting;
        int          flushLeft;
    } model_t;

    typedef struct {
        model_t a;
        model_t b;
    } exp_t;

    model_t mA, mB;
    exp_t   expQ[$];
    int     testsRun = 0;
    int     testsFailed = 0;

    function automatic model_t modelReset(input logic [31:0] rpc);
        model_t m;
        m.pc = rpc;
        m.pcDec = rpc;
        m.lrVal = 32'h0;
        m.lrWe = 1'b0;
        m.ispb = 1'b0;
        m.ifetch = 1'b0;
        m.waiting = 1'b0;
        m.flushLeft = 0;
        return m;
    endfunction

    // One clock of fetch behaviour written from the controller's rules.
    function automatic model_t modelStep(input model_t m, input int flushCyc, input logic rdy,
                                         input logic h, input logic b, input logic [31:0] off,
                                         input logic link);
        model_t      n;
        logic [31:0] offW;
        logic        moving;
        n = m;
        n.lrWe = 1'b0;
        n.ifetch = 1'b1;
        offW = {off[31:2], 2'b00};
        moving = 1'b0;
        if (m.flushLeft > 0) begin
            moving = rdy && !h;
            n.flushLeft = m.flushLeft - 1;
        end else if (m.waiting) begin
            moving = rdy && !h;
            if (moving) n.waiting = 1'b0;
        end else if (!h) begin
            if (b) begin
                n.pc = m.pcDec + 32'd8 + offW;
                n.flushLeft = flushCyc;
                if (link) begin
                    n.lrWe = 1'b1;
                    n.lrVal = m.pcDec + 32'd4;
                end
            end else if (!rdy) begin
                n.waiting = 1'b1;
            end else begin
                moving = 1'b1;
            end
        end
        if (moving) begin
            n.pcDec = m.pc;
            n.pc = m.pc + 32'd4;
        end
        n.ispb = (n.flushLeft > 0);
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rdy, input logic h, input logic b,
                                 input logic [31:0] off, input logic link);
        exp_t e;
        @(negedge clk);
        rst = 1'b1;
        imem_rdy = rdy;
        hold = h;
        ib = b;
        bv = off;
        bl = link;
        mA = modelStep(mA, 1, rdy, h, b, off, link);
        mB = modelStep(mB, 3, rdy, h, b, off, link);
        e.a = mA;
        e.b = mB;
        expQ.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Reset is asserted between clock edges and checked before any edge arrives.
    task automatic doReset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("rstA_pc", pcA, RESET_A);
        checkOutput("rstA_pc_dec", pcDecA, RESET_A);
        checkOutput("rstA_ispb", 32'(ispbA), 32'h0);
        checkOutput("rstA_ifetch", 32'(ifetchA), 32'h0);
        checkOutput("rstA_lr_we", 32'(lrWeA), 32'h0);
        checkOutput("rstA_lr_val", lrValA, 32'h0);
        checkOutput("rstB_pc", pcB, RESET_B);
        checkOutput("rstB_pc_dec", pcDecB, RESET_B);
        checkOutput("rstB_ispb", 32'(ispbB), 32'h0);
        checkOutput("rstB_ifetch", 32'(ifetchB), 32'h0);
        checkOutput("rstB_lr_we", 32'(lrWeB), 32'h0);
        checkOutput("rstB_lr_val", lrValB, 32'h0);
        mA = modelReset(RESET_A);
        mB = modelReset(RESET_B);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("A_pc", pcA, e.a.pc);
                checkOutput("A_pc_dec", pcDecA, e.a.pcDec);
                checkOutput("A_ifetch", 32'(ifetchA), 32'(e.a.ifetch));
                checkOutput("A_ispb", 32'(ispbA), 32'(e.a.ispb));
                checkOutput("A_lr_we", 32'(lrWeA), 32'(e.a.lrWe));
                checkOutput("A_lr_val", lrValA, e.a.lrVal);
                checkOutput("B_pc", pcB, e.b.pc);
                checkOutput("B_pc_dec", pcDecB, e.b.pcDec);
                checkOutput("B_ifetch", 32'(ifetchB), 32'(e.b.ifetch));
                checkOutput("B_ispb", 32'(ispbB), 32'(e.b.ispb));
                checkOutput("B_lr_we", 32'(lrWeB), 32'(e.b.lrWe));
                checkOutput("B_lr_val", lrValB, e.b.lrVal);
            end
        end
    end

    initial begin : driver
        mA = modelReset(RESET_A);
        mB = modelReset(RESET_B);
        doReset();

        for (int k = 1; k <= 9; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
            settle();
            checkOutput("seq_pc", pcA, 32'(4 * k));
            checkOutput("seq_pc_dec", pcDecA, 32'(4 * (k - 1)));
            checkOutput("seq_ispb", 32'(ispbA), 32'h0);
        end

        applyStimulus(1'b1, 1'b0, 1'b1, 32'h10, 1'b1);
        settle();
        checkOutput("br_pc", pcA, 32'h38);
        checkOutput("br_lr_we", 32'(lrWeA), 32'h1);
        checkOutput("br_lr_val", lrValA, 32'h24);
        checkOutput("br_ispb", 32'(ispbA), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("br_ispb_end", 32'(ispbA), 32'h0);
        checkOutput("br_lr_we_end", 32'(lrWeA), 32'h0);
        checkOutput("br_lr_val_hold", lrValA, 32'h24);
        checkOutput("br_flush_pc", pcA, 32'h3C);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
            settle();
            checkOutput("hold_pc", pcA, 32'h3C);
            checkOutput("hold_ispb", 32'(ispbA), 32'h0);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
        settle();
        checkOutput("hold_release_pc", pcA, 32'h80);
        checkOutput("hold_release_ispb", 32'(ispbA), 32'h1);

        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("first_ifetch", 32'(ifetchA), 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            settle();
            checkOutput("wait_pc", pcA, 32'h8);
            checkOutput("wait_ifetch", 32'(ifetchA), 32'h1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("wait_done_pc", pcA, 32'hC);
        checkOutput("wait_done_pc_dec", pcDecA, 32'h8);

        applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFE0, 1'b0);
        settle();
        checkOutput("wrap_setup_pc", pcA, 32'hFFFF_FFF0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("wrap_setup_pc_dec", pcDecA, 32'hFFFF_FFF0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h8, 1'b0);
        settle();
        checkOutput("wrap_branch_pc", pcA, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h3, 1'b0);
        settle();
        checkOutput("bv_low_bits_pc", pcA, 32'hFFFF_FFF8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("wrap_seq_pc", pcA, 32'h0);
        checkOutput("wrap_seq_pc_dec", pcDecA, 32'hFFFF_FFFC);

        doReset();
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        settle();
        checkOutput("flush3_ispb_mid", 32'(ispbB), 32'h1);
        doReset();

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                doReset();
            end else begin
                applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0),
                              1'($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 1)));
            end
        end

        @(posedge clk);
        #3;
        checkOutput("queue_drained", 32'(expQ.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fetch_ctl.md
FETCH_CTL -- requirements
Module: fetch_ctl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, word-aligned PC loaded at reset.
REQ-002 SHALL provide parameter FLUSH_CYC, default 1, number of squash cycles after a taken branch, legal range 1..3.
REQ-003 SHALL use one clock and an asynchronous active-low reset, with ports as listed below.
REQ-004 clk  in  1  system clock, all state updates on rising edge.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 imem_rdy  in  1  instruction memory returned data for the current pc this cycle.
REQ-007 hold  in  1  downstream stall; pc and pc_dec frozen.
REQ-008 ib  in  1  taken branch from the decoder.
REQ-009 bv  in  32  signed byte offset from the decoder, already shifted.
REQ-010 bl  in  1  branch with link.
REQ-011 pc  out  32  current fetch address.
REQ-012 ifetch  out  1  fetch request to instruction memory.
REQ-013 pc_dec  out  32  address of the instruction presently in decode.
REQ-014 ispb  out  1  squash flag to the decoder.
REQ-015 lr_we  out  1  write-enable for r14.
REQ-016 lr_val  out  32  link value for r14.

Function
REQ-017 SHALL implement states RUN, WAIT, FLUSH, encoded in 2 bits.
REQ-018 RUN, ifetch=1, first match wins:
- hold=1: stay in RUN; pc, pc_dec unchanged; ib ignored that cycle.
- ib=1: pc <= pc_dec+8+bv; go to FLUSH; load cnt=FLUSH_CYC.
- imem_rdy=0: go to WAIT; pc unchanged.
- otherwise: pc_dec <= pc; pc <= pc+4.
REQ-019 In WAIT, ifetch SHALL be 1 and pc held; on imem_rdy=1 with hold=0, pc_dec <= pc, pc <= pc+4, and the state returns to RUN; otherwise the state stays WAIT.
REQ-020 In FLUSH, ispb SHALL be 1, ifetch SHALL be 1, and pc SHALL advance by 4 on each imem_rdy=1.
- cnt decrements each cycle.
- ib ignored.
- Transition to RUN occurs on the cycle cnt reaches 1, so ispb is high exactly FLUSH_CYC cycles.
REQ-021 ispb SHALL be 0 in RUN and WAIT.
REQ-022 lr_we SHALL pulse 1 for exactly the cycle a branch is taken with bl=1; in that cycle lr_val = pc_dec+4. Otherwise lr_we=0 and lr_val holds its last value.
REQ-023 All address arithmetic SHALL be 32-bit modulo 2^32, wrapping silently (e.g. 32'hFFFF_FFFC+4 = 32'h0).
REQ-024 pc[1:0] SHALL always be 2'b00; bv[1:0] SHALL be ignored.
REQ-025 Branch-taken latency: the new pc SHALL be visible on the cycle after ib is sampled with hold=0.
REQ-026 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-027 When rst=0, asynchronously: pc=RESET_PC, pc_dec=RESET_PC, state=RUN, cnt=0, ispb=0, lr_we=0, lr_val=0, ifetch=0.
REQ-028 On the first rising clk after rst deasserts, ifetch SHALL be 1.
REQ-029 Reset asserted mid-FLUSH or mid-WAIT SHALL abort the operation and apply REQ-027 with no further lr_we.

Verification
REQ-030 Reset release with imem_rdy=1 and hold=0 for 4 cycles -> pc sequence 0,4,8,C,10; pc_dec lags pc by one cycle; ispb=0 throughout.
REQ-031 Branch: pc_dec=32'h20, ib=1, bv=32'h10, bl=1 -> next cycle pc=32'h38, lr_we=1, lr_val=32'h24; ispb=1 for 1 cycle (FLUSH_CYC=1), then RUN.
REQ-032 Hold: assert ib=1 with hold=1 for 3 cycles, then drop hold -> no pc change during hold; branch taken on the release cycle.
REQ-033 Wait: imem_rdy=0 for 2 cycles at pc=32'h8 -> pc stays 32'h8 with ifetch=1; on imem_rdy=1, pc=32'hC.
REQ-034 Wrap: pc_dec=32'hFFFF_FFF0, bv=32'h8 -> pc=32'h0; separately, sequential fetch from 32'hFFFF_FFFC -> pc=32'h0.
REQ-035 Reset asserted on the 2nd cycle of FLUSH with FLUSH_CYC=3 -> ispb=0 and pc=RESET_PC immediately, without waiting for clk.
